cl_unpacker: RTL and testbench
==============================

# cl_unpacker

Read-side counterpart of the AFU result packer. It pops 512-bit cache lines from the DMA read FIFO and unpacks each into 16 32-bit words, least-significant word first. Each word is truncated to OUT_WIDTH bits and streamed out over a valid/ready handshake. It sits between the DMA read channel and any consumer that takes per-word host data, such as RO configuration or RSA operand loading, and counts a software-programmed number of lines.

## Interface
- CL_DATA_WIDTH, 512: cache-line width in bits.
- WORD_WIDTH, 32: packed word width; must divide CL_DATA_WIDTH.
- OUT_WIDTH, 20: emitted width, ≤ WORD_WIDTH; the low OUT_WIDTH bits of each word are kept.
- SIZE_WIDTH, 65: width of the line count.
- WORDS_PER_CL: derived, CL_DATA_WIDTH/WORD_WIDTH (16).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- go  in  1  start pulse; honoured only in IDLE or DONE.
- num_lines  in  SIZE_WIDTH  lines to consume; sampled on an accepted go.
- rd_empty  in  1  DMA read FIFO empty.
- rd_data  in  CL_DATA_WIDTH  head of the DMA FIFO (first-word-fall-through); valid while !rd_empty.
- rd_en  out  1  pops the FIFO head; never asserted while rd_empty.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid && out_ready.
- out_data  out  OUT_WIDTH  current word, truncated.
- out_last  out  1  marks the final word of the final line; qualified by out_valid.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; held until the next accepted go or rst.

## Operation
- States are IDLE, RUN and DONE. Reset state is IDLE.
- Registers: line buffer buf_r (CL_DATA_WIDTH), word counter words_r (0..WORDS_PER_CL), lines-remaining counter left_r (SIZE_WIDTH).
- IDLE/DONE on go:
  - left_r ← num_lines, words_r ← 0, done ← 0.
  - If num_lines == 0, go to DONE. Otherwise go to RUN.
- RUN load condition: load = (words_r == 0 || (words_r == 1 && out_valid && out_ready)) && left_r != 0 && !rd_empty.
- rd_en = load, asserted combinationally.
- On load: buf_r ← rd_data, words_r ← WORDS_PER_CL, left_r ← left_r − 1.
- On a transfer without load: buf_r shifts right by WORD_WIDTH (zero fill), words_r ← words_r − 1.
- When a transfer and a load happen in the same cycle, the load wins for buf_r and words_r.
- out_valid = (words_r != 0).
- out_data = buf_r[OUT_WIDTH-1:0]. Bits WORD_WIDTH-1:OUT_WIDTH are discarded.
- out_last = out_valid && words_r == 1 && left_r == 0.
- A transfer with out_last set moves the FSM to DONE in the next cycle.
- go while in RUN is ignored: no counter, buffer or output change.
- out_data is held stable while out_valid && !out_ready.
- rst asserted mid-RUN:
  - Returns to IDLE immediately and clears all counters and outputs.
  - The current line is lost; no rd_en is issued during reset.

## Timing
- Reset values: rd_en 0, out_valid 0, out_data 0, out_last 0, busy 0, done 0.
- go to first rd_en: rd_en can assert in the first RUN cycle, i.e. one cycle after go, if !rd_empty.
- rd_en to out_valid: 1 cycle.
- Throughput with out_ready held high and the FIFO non-empty: one word per cycle, no bubbles across line boundaries. The next line is popped in the same cycle as word 15's transfer.
- Final transfer to done: done asserts 1 cycle after the final transfer. busy deasserts in that same cycle.
- go with num_lines == 0: done rises 1 cycle after go; rd_en is never asserted.
- When rd_empty is high with words_r == 0: out_valid goes low and the block waits with no timeout.
- left_r never wraps: it never decrements below 0, and rd_en is gated by left_r != 0.

## Test plan
- num_lines=1, FIFO holds one line with word i = 32'h000A_0000 + i, out_ready=1:
  - Expect 16 consecutive transfers with out_data = 20'hA_0000 + i, i = 0..15.
  - out_last only on i=15; exactly one rd_en pulse; done 1 cycle after the last transfer.
- num_lines=3, FIFO pre-filled, out_ready=1:
  - Expect 48 transfers in 48 consecutive cycles.
  - rd_en pulses in the cycles of transfers 15 and 31 as well as the first RUN cycle; total of 3 pulses.
- Backpressure: out_ready toggles 1,0,0,1 repeating.
  - out_data is stable during stalls; no word is skipped or duplicated; word order is preserved.
- FIFO starvation: the second line arrives 10 cycles after the first line drains.
  - out_valid is low for those cycles; rd_en is never asserted while rd_empty; the output resumes correctly.
- num_lines=0 go:
  - done=1 the next cycle, no rd_en, no out_valid.
  - A second go during RUN of a 2-line job has no effect and exactly 32 words are emitted.
- Assert rst after 5 words of a 2-line job:
  - All outputs are 0 in the same cycle, the state is IDLE, and no rd_en occurs during reset.
  - A fresh go with num_lines=1 then emits 16 words correctly.

Source files
------------

// File: rtl/cl_unpacker.sv
// Cache-line unpacker: pops 512-bit lines from the DMA read FIFO and
// streams them out as truncated words, least-significant word first.
module cl_unpacker #(
   parameter int CL_DATA_WIDTH = 512,
   parameter int WORD_WIDTH    = 32,
   parameter int OUT_WIDTH     = 20,
   parameter int SIZE_WIDTH    = 65
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     go,
   input  logic [SIZE_WIDTH-1:0]    num_lines,
   input  logic                     rd_empty,
   input  logic [CL_DATA_WIDTH-1:0] rd_data,
   output logic                     rd_en,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_WIDTH-1:0]     out_data,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done
);

   localparam int WORDS_PER_CL = CL_DATA_WIDTH / WORD_WIDTH;
   localparam int CW = $clog2(WORDS_PER_CL + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t                   state_r;
   logic [CL_DATA_WIDTH-1:0] buf_r;
   logic [CW-1:0]            words_r;
   logic [SIZE_WIDTH-1:0]    left_r;

   logic xfer;
   logic last_word;
   logic lines_left;
   logic load;

   assign xfer       = out_valid && out_ready;
   assign last_word  = (words_r == CW'(1));
   assign lines_left = (left_r != '0);

   // Refill either when empty or while the final word of the line leaves,
   // so consecutive lines stream without a bubble.
   assign load = (state_r == RUN)
              && ((words_r == '0) || (last_word && xfer))
              && lines_left
              && !rd_empty;

   assign rd_en     = load;
   assign out_valid = (words_r != '0);
   assign out_data  = buf_r[OUT_WIDTH-1:0];
   assign out_last  = out_valid && last_word && !lines_left;
   assign busy      = (state_r == RUN);
   assign done      = (state_r == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         buf_r   <= '0;
         words_r <= '0;
         left_r  <= '0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (go) begin
                  left_r  <= num_lines;
                  words_r <= '0;
                  buf_r   <= '0;
                  state_r <= (num_lines == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (load) begin
                  buf_r   <= rd_data;
                  words_r <= CW'(WORDS_PER_CL);
                  left_r  <= left_r - SIZE_WIDTH'(1);
               end else if (xfer) begin
                  buf_r   <= buf_r >> WORD_WIDTH;
                  words_r <= words_r - CW'(1);
               end
               if (xfer && out_last)
                  state_r <= DONE;
            end
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cl_unpacker.sv
// Randomized bench for cl_unpacker with a queue-based FIFO and word model.
module tb_cl_unpacker;

   logic         clk = 1'b0;
   logic         rst;
   logic         go;
   logic [64:0]  num_lines;
   logic         rd_empty;
   logic [511:0] rd_data;
   logic         rd_en;
   logic         out_valid;
   logic         out_ready;
   logic [19:0]  out_data;
   logic         out_last;
   logic         busy;
   logic         done;

   int n_chk  = 0;
   int n_fail = 0;

   logic [511:0] fifo[$];
   logic [511:0] pend[$];
   logic [19:0]  exp_q[$];

   cl_unpacker dut (
      .clk       (clk),
      .rst       (rst),
      .go        (go),
      .num_lines (num_lines),
      .rd_empty  (rd_empty),
      .rd_data   (rd_data),
      .rd_en     (rd_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   task automatic drive_fifo();
      rd_empty = (fifo.size() == 0);
      rd_data  = (fifo.size() != 0) ? fifo[0] : '0;
   endtask

   // mode: 0 ready always, 1 pattern 1,0,0,1, 2 random
   // gap: >0 delivers each later line gap cycles after the previous drains
   task automatic run_job(input int n, input int mode, input int gap,
                          input bit pat, input bit go_in_run,
                          input int rst_at);
      logic [511:0] line;
      logic [31:0]  word;
      int pops, xfers, cycles, limit, gap_cnt, first_c, last_c;
      bit   stall_prev, xfer;
      logic [19:0] prev_data;
      fifo.delete();
      pend.delete();
      exp_q.delete();
      for (int l = 0; l < n; l++) begin
         for (int w = 0; w < 16; w++) begin
            word = pat ? (32'h000A_0000 + w) : $urandom;
            line[w*32 +: 32] = word;
            exp_q.push_back(word[19:0]);
         end
         if (gap > 0 && l > 0) pend.push_back(line);
         else fifo.push_back(line);
      end
      @(negedge clk);
      drive_fifo();
      go = 1'b1;
      num_lines = 65'(n);
      @(posedge clk);
      #1 go = 1'b0;
      pops = 0; xfers = 0; cycles = 0; gap_cnt = 0;
      first_c = -1; last_c = -1;
      stall_prev = 1'b0; prev_data = '0;
      limit = 16 * n * 6 + 200;
      while (xfers < 16 * n && cycles < limit) begin
         @(negedge clk);
         if (gap_cnt > 0) begin
            gap_cnt--;
            if (gap_cnt == 0 && pend.size() != 0)
               fifo.push_back(pend.pop_front());
         end
         drive_fifo();
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = (cycles % 4 == 0) || (cycles % 4 == 3);
            default: out_ready = 1'($urandom % 2);
         endcase
         go = go_in_run && (cycles == 3);
         num_lines = go ? 65'd7 : num_lines;
         #1;
         chk("busy", busy, 1);
         chk("out_valid", out_valid, (pops * 16 != xfers));
         if (rd_en) chk("rd_en_empty", rd_empty, 0);
         if (stall_prev) chk("stall_hold", out_data, prev_data);
         xfer = out_valid && out_ready;
         if (rd_en && mode == 0 && gap == 0 && pops > 0)
            chk("pop_w15", (xfer && (xfers % 16 == 15)), 1);
         if (xfer && exp_q.size() != 0) begin
            chk("data", out_data, exp_q.pop_front());
            chk("last", out_last, (exp_q.size() == 0));
            if (first_c < 0) first_c = cycles;
            last_c = cycles;
         end else if (!xfer) begin
            if (out_valid) chk("last_q", out_last, (xfers == 16 * n - 1));
         end
         stall_prev = out_valid && !out_ready;
         prev_data = out_data;
         @(posedge clk);
         if (rd_en) begin
            pops++;
            void'(fifo.pop_front());
         end
         if (xfer) begin
            xfers++;
            if (gap > 0 && xfers % 16 == 0 && pend.size() != 0)
               gap_cnt = gap;
         end
         cycles++;
         #1 go = 1'b0;
         if (rst_at > 0 && xfers == rst_at) break;
      end
      if (rst_at > 0) begin
         @(negedge clk);
         drive_fifo();
         out_ready = 1'b1;
         rst = 1'b1;
         #1;
         chk("rst_rd_en", rd_en, 0);
         chk("rst_valid", out_valid, 0);
         chk("rst_data", out_data, 0);
         chk("rst_last", out_last, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         repeat (2) begin
            @(negedge clk);
            #1 chk("rst_hold_rd_en", rd_en, 0);
         end
         rst = 1'b0;
         fifo.delete();
         drive_fifo();
         @(negedge clk);
         #1 chk("rst_idle_busy", busy, 0);
         return;
      end
      chk("timeout", (cycles < limit), 1);
      chk("rd_en_count", pops, n);
      if (mode == 0 && gap == 0)
         chk("throughput", last_c - first_c, 16 * n - 1);
      @(negedge clk);
      drive_fifo();
      #1;
      chk("done", done, 1);
      chk("busy_end", busy, 0);
      chk("valid_end", out_valid, 0);
   endtask

   initial begin
      rst = 1'b1;
      go = 1'b0;
      num_lines = '0;
      rd_empty = 1'b1;
      rd_data = '0;
      out_ready = 1'b0;
      #1;
      chk("reset_rd_en", rd_en, 0);
      chk("reset_valid", out_valid, 0);
      chk("reset_data", out_data, 0);
      chk("reset_last", out_last, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      run_job(1, 0, 0, 1'b1, 1'b0, 0);
      run_job(3, 0, 0, 1'b0, 1'b0, 0);
      run_job(3, 1, 0, 1'b0, 1'b0, 0);
      run_job(2, 0, 10, 1'b0, 1'b0, 0);
      run_job(3, 2, 4, 1'b0, 1'b0, 0);

      // zero-line job with a line waiting proves nothing is popped
      fifo.delete();
      fifo.push_back({16{32'h1234_5678}});
      @(negedge clk);
      drive_fifo();
      go = 1'b1;
      num_lines = '0;
      #1 chk("zero_rd_en_go", rd_en, 0);
      @(posedge clk);
      #1 go = 1'b0;
      @(negedge clk);
      #1;
      chk("zero_done", done, 1);
      chk("zero_rd_en", rd_en, 0);
      chk("zero_valid", out_valid, 0);
      chk("zero_busy", busy, 0);

      run_job(2, 0, 0, 1'b0, 1'b1, 0);
      run_job(2, 0, 0, 1'b0, 1'b0, 5);
      run_job(1, 0, 0, 1'b1, 1'b0, 0);
      run_job(2, 2, 0, 1'b0, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
